inst_fetch_ctrl: RTL

Instruction fetch controller that sequences the byte-addressed, combinational-read `Instruction_Memory`. It owns the program counter and drives `address_bus_IR`. It captures the 32-bit big-endian word returned on `inst_mem_bus_IR` into a 2-entry queue and presents instructions to decode over a valid/ready handshake. It also handles branch/jump redirects, stalls from decode, and out-of-range or misaligned fetch faults.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/inst_fetch_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;
    localparam int PKG_XLEN   = 32;
    localparam int INST_BYTES = 4;

    // Any of these low address bits set means the fetch address is misaligned.
    localparam logic [PKG_XLEN-1:0] ALIGN_MASK = PKG_XLEN'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {pc, inst} pairs between fetch and decode.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot the same cycle; flush wins.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);
    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = slots[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer/count update; flush only rewinds pointers, storage keeps stale data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slots[0] <= '0;
            slots[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives memory, queues words for decode.
// Latency: address in FETCH cycle N gives inst_valid in N+1; redirect target valid at N+2.
// Backpressure: PC stalls while the queue is full and decode does not accept the head.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              MEM_BYTES = 128,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    output logic [XLEN-1:0] address_bus_IR,
    input  logic [XLEN-1:0] inst_mem_bus_IR,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);
    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - INST_BYTES);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            pc_legal;
    logic            fire;
    logic            do_push;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;

    // A fetch address is usable only if word aligned and the whole word lies in memory.
    function automatic logic is_legal(input logic [XLEN-1:0] addr);
        return ((addr & XLEN'(ALIGN_MASK)) == '0) && (addr <= LAST_PC);
    endfunction

    assign pc_legal       = is_legal(pc);
    assign address_bus_IR = pc;
    assign inst_valid     = !q_empty;
    assign fire           = inst_valid && inst_ready;
    assign inst_out       = q_head.inst;
    assign inst_pc        = q_head.pc;
    assign q_in           = '{pc: pc, inst: inst_mem_bus_IR};

    // Redirect suppresses any fetch in its cycle; otherwise fetch needs space or a same-cycle pop.
    assign do_push = (state == FETCH) && fetch_en && !redirect_valid && pc_legal
                     && (!q_full || fire);

    fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (do_push),
        .push_data (q_in),
        .pop       (fire),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Fetch FSM with PC and fault registers; redirect outranks fault detection and fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            fetch_fault <= 1'b0;
            case (state)
                FETCH:   if (!fetch_en) state <= IDLE;
                HALT:    if (is_legal(redirect_pc)) state <= fetch_en ? FETCH : IDLE;
                default: state <= state;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) state <= FETCH;
                end
                FETCH: begin
                    if (!fetch_en) begin
                        state <= IDLE;
                    end else if (!pc_legal) begin
                        fetch_fault <= 1'b1;
                        fault_pc    <= pc;
                        state       <= HALT;
                    end else if (do_push) begin
                        pc <= pc + XLEN'(INST_BYTES);
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule
